// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit between the schoolRISCV execute stage and a
// word-wide data-memory bus. One byte/half/word (dword when XLEN=64) access
// per request, handshake FSM tolerant of memory wait states.
// Optional feature macro: SR_LSU_MISALIGNED_EN -- when defined, accesses that
// cross an XLEN/8 boundary are split into two bus beats; when undefined they
// return resp_err without touching the bus.
module sr_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sign,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic                resp_err,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                busy,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned XW   = XLEN;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
`ifdef SR_LSU_MISALIGNED_EN
        BEAT1 = 2'd2,
`endif
        RESP  = 2'd3
    } state_t;

    state_t            state;
    logic              weR;
    logic [1:0]        sizeR;
    logic              signR;
    logic [OFFW-1:0]   offR;

    logic              accept;
    logic              reqIllegal;
    logic              reqCross;
    int unsigned       reqOff;
    int unsigned       reqBytes;
    int unsigned       loShift;
    logic [NB-1:0]     beLo;
    logic [ADDR_W-1:0] alignedAddr;

`ifdef SR_LSU_MISALIGNED_EN
    localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(NB);
    logic              splitR;
    logic [NB-1:0]     beHiR;
    logic [XLEN-1:0]   wdataR;
    logic [XLEN-1:0]   rdLow;
    logic [NB-1:0]     beHi;
    int unsigned       hiShift;
`endif

    // Right-aligned load data -> sign/zero-extended to XLEN; full-width loads pass through.
    function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] d,
                                                   input logic [1:0] size,
                                                   input logic sgn);
        logic [XLEN-1:0] lowMask;
        int unsigned     nbits;
        nbits   = 32'd8 << size;
        lowMask = '1;
        if (nbits < XW) lowMask = ~(lowMask << nbits);
        extendLoad = d & lowMask;
        if (sgn && (nbits < XW) && d[nbits-1]) extendLoad = extendLoad | ~lowMask;
    endfunction

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Request decode: lane offset, size legality, boundary crossing, byte enables.
    always_comb begin
        accept      = req_valid && req_ready;
        reqOff      = 32'(req_addr[OFFW-1:0]);
        reqBytes    = 32'd1 << req_size;
        reqIllegal  = (XW == 32'd32) && (req_size == 2'd3);
        reqCross    = (reqOff + reqBytes) > NB;
        alignedAddr = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        loShift     = 8 * 32'(offR);
        beLo        = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            beLo[i] = (i >= reqOff) && (i < reqOff + reqBytes);
        end
`ifdef SR_LSU_MISALIGNED_EN
        hiShift = 8 * (NB - 32'(offR));
        beHi    = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            beHi[i] = (i + NB) < (reqOff + reqBytes);
        end
`endif
    end

    // Handshake FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            weR        <= 1'b0;
            sizeR      <= '0;
            signR      <= 1'b0;
            offR       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
`ifdef SR_LSU_MISALIGNED_EN
            splitR     <= 1'b0;
            beHiR      <= '0;
            wdataR     <= '0;
            rdLow      <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        weR   <= req_we;
                        sizeR <= req_size;
                        signR <= req_sign;
                        offR  <= req_addr[OFFW-1:0];
`ifdef SR_LSU_MISALIGNED_EN
                        if (reqIllegal) begin
`else
                        if (reqIllegal || reqCross) begin
`endif
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= alignedAddr;
                            mem_be    <= beLo;
                            mem_wdata <= req_wdata << (8 * reqOff);
`ifdef SR_LSU_MISALIGNED_EN
                            splitR    <= reqCross;
                            beHiR     <= beHi;
                            wdataR    <= req_wdata;
`endif
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready) begin
`ifdef SR_LSU_MISALIGNED_EN
                        if (splitR) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + BEAT_STRIDE;
                            mem_be    <= beHiR;
                            mem_wdata <= wdataR >> hiShift;
                            rdLow     <= mem_rdata >> loShift;
                        end else begin
`else
                        begin
`endif
                            state      <= RESP;
                            mem_valid  <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= weR ? '0 : extendLoad(mem_rdata >> loShift, sizeR, signR);
                        end
                    end
                end
`ifdef SR_LSU_MISALIGNED_EN
                BEAT1: begin
                    if (mem_ready) begin
                        state      <= RESP;
                        mem_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        // beat0 supplied the low-order bytes, beat1 the remainder above them
                        resp_rdata <= weR ? '0 : extendLoad(rdLow | (mem_rdata << hiShift), sizeR, signR);
                    end
                end
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_lsu.sv
// Self-checking bench for sr_lsu: XLEN=32 instance for the main scenarios,
// XLEN=64 instance for dword access. Expectations follow SR_LSU_MISALIGNED_EN.
module tb_sr_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err, busy, mem_valid, mem_we;
    logic        mem_ready = 1'b1;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_be;

    logic        req_valid64 = 1'b0, req_ready64, req_we64 = 1'b0, req_sign64 = 1'b0;
    logic [1:0]  req_size64 = 2'd0;
    logic [31:0] req_addr64 = '0;
    logic [63:0] req_wdata64 = '0;
    logic        resp_valid64, resp_err64, busy64, mem_valid64, mem_we64;
    logic        mem_ready64 = 1'b1;
    logic [63:0] resp_rdata64, mem_wdata64;
    logic [63:0] mem_rdata64 = '0;
    logic [31:0] mem_addr64;
    logic [7:0]  mem_be64;

    always #5 clk = ~clk;

    sr_lsu #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .busy(busy), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    sr_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
        .req_size(req_size64), .req_sign(req_sign64), .req_addr(req_addr64),
        .req_wdata(req_wdata64), .resp_valid(resp_valid64), .resp_err(resp_err64),
        .resp_rdata(resp_rdata64), .busy(busy64), .mem_valid(mem_valid64),
        .mem_ready(mem_ready64), .mem_we(mem_we64), .mem_addr(mem_addr64),
        .mem_be(mem_be64), .mem_wdata(mem_wdata64), .mem_rdata(mem_rdata64)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sgn;
        req_addr = addr; req_wdata = wd;
        step;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        step; step;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b want 0", mem_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be got %h want 0", mem_be); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        checks++; if (mem_valid64 !== 1'b0) begin errors++; $display("FAIL rst_mem_valid64 got %b want 0", mem_valid64); end
        rst = 1'b0;
        step;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got %b want 1", req_ready); end
    endtask

    task automatic test_load_byte;
        mem_ready = 1'b1; mem_rdata = 32'h80AA_BBCC;
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL lb_mem_valid got %b want 1", mem_valid); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL lb_mem_addr got %h want 100", mem_addr); end
        checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL lb_mem_be got %b want 1000", mem_be); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL lb_mem_we got %b want 0", mem_we); end
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL lb_busy got %b/%b want 1/0", busy, req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lb_early_resp got %b want 0", resp_valid); end
        step;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lb_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext got %h want ffffff80", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL lb_err got %b want 0", resp_err); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL lb_mem_drop got %b want 0", mem_valid); end
        step;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lb_pulse got %b/%b want 0/1", resp_valid, req_ready); end
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        step;
        checks++; if (resp_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lb_zext got %h want 00000080", resp_rdata); end
        step;
        mem_rdata = 32'h80AA_BBCC;
        issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0);
        checks++; if (mem_be !== 4'b0110) begin errors++; $display("FAIL lh_off1_be got %b want 0110", mem_be); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL lh_off1_resp got %b/%b want 1/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'hFFFF_AABB) begin errors++; $display("FAIL lh_off1_data got %h want ffffaabb", resp_rdata); end
        step;
    endtask

    task automatic test_store_half;
        mem_ready = 1'b1;
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF);
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL sh_addr got %h want 200", mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", mem_be); end
        checks++; if (mem_wdata[31:16] !== 16'hBEEF) begin errors++; $display("FAIL sh_wdata got %h want beef", mem_wdata[31:16]); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sh_we got %b want 1", mem_we); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL sh_resp got %b/%b want 1/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL sh_rdata got %h want 0", resp_rdata); end
        step;
    endtask

    task automatic test_split;
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
        issue(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0);
`ifdef SR_LSU_MISALIGNED_EN
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h1FC) begin errors++; $display("FAIL sp_b0_addr got %b/%h want 1/1fc", mem_valid, mem_addr); end
        checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL sp_b0_be got %b want 1100", mem_be); end
        step;
        mem_rdata = 32'h5566_7788;
        checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h200) begin errors++; $display("FAIL sp_b1_addr got %b/%h want 1/200", mem_valid, mem_addr); end
        checks++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL sp_b1_be got %b want 0011", mem_be); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL sp_early_resp got %b want 0", resp_valid); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL sp_resp got %b/%b want 1/0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h7788_1122) begin errors++; $display("FAIL sp_rdata got %h want 77881122", resp_rdata); end
        step;
        issue(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD);
        checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_be !== 4'b1000) begin errors++; $display("FAIL spw_b0 got %h/%b want fffffffc/1000", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'hCD00_0000) begin errors++; $display("FAIL spw_b0_wdata got %h want cd000000", mem_wdata); end
        step;
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'b0001) begin errors++; $display("FAIL spw_b1 got %h/%b want 00000000/0001", mem_addr, mem_be); end
        checks++; if (mem_wdata !== 32'h0000_00AB || mem_we !== 1'b1) begin errors++; $display("FAIL spw_b1_wdata got %h/%b want 000000ab/1", mem_wdata, mem_we); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin errors++; $display("FAIL spw_resp got %b/%h want 1/0", resp_valid, resp_rdata); end
        step;
`else
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL sp_err got %b/%b want 1/1", resp_valid, resp_err); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sp_no_beat got %b want 0", mem_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL sp_err_rdata got %h want 0", resp_rdata); end
        step;
        checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL sp_after got %b/%b want 0/0", mem_valid, resp_valid); end
        issue(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD);
        checks++; if (resp_err !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL spw_err got %b/%b want 1/0", resp_err, mem_valid); end
        step;
`endif
    endtask

    task automatic test_wait_states;
        mem_ready = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) mem_ready = 1'b1;
            checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h40 || mem_be !== 4'hF || mem_we !== 1'b1)
                begin errors++; $display("FAIL ws_hold%0d got %b/%h/%h/%b want 1/40/f/1", i, mem_valid, mem_addr, mem_be, mem_we); end
            checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_wdata%0d got %h want deadbeef", i, mem_wdata); end
            checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL ws_ready%0d got %b/%b want 0/0", i, req_ready, resp_valid); end
            if (i == 2) begin req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; end
            if (i == 3) req_valid = 1'b0;
            step;
        end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL ws_resp got %b/%b/%h want 1/0/0", resp_valid, resp_err, resp_rdata); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL ws_drop got %b want 0", mem_valid); end
        step;
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL ws_no_queue got %b/%b/%b want 0/1/0", mem_valid, req_ready, resp_valid); end
    endtask

    task automatic test_illegal_size;
        mem_ready = 1'b1;
        issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL sz3_err got %b/%b want 1/1", resp_valid, resp_err); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL sz3_no_beat got %b want 0", mem_valid); end
        step;
        checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sz3_after got %b/%b want 0/1", mem_valid, req_ready); end
    endtask

    task automatic test_back_to_back;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        checks++; if (mem_addr !== 32'h10 || mem_be !== 4'hF) begin errors++; $display("FAIL b2b_a got %h/%h want 10/f", mem_addr, mem_be); end
        step;
        checks++; if (resp_rdata !== 32'h1234_5678 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_a_resp got %h/%b want 12345678/0", resp_rdata, req_ready); end
        step;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        checks++; if (mem_be !== 4'b0010) begin errors++; $display("FAIL b2b_b_be got %b want 0010", mem_be); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0056) begin errors++; $display("FAIL b2b_b_resp got %b/%h want 1/00000056", resp_valid, resp_rdata); end
        step;
    endtask

    task automatic test_reset_mid;
        mem_ready = 1'b0;
        issue(1'b1, 2'd2, 1'b0, 32'h80, 32'h1111_2222);
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rm_beat got %b want 1", mem_valid); end
        rst = 1'b1;
        step;
        checks++; if (mem_valid !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rm_abort got %b/%b/%b want 0/0/0", mem_valid, busy, resp_valid); end
        rst = 1'b0;
        step;
        checks++; if (resp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle got %b/%b/%b want 0/0/1", resp_valid, mem_valid, req_ready); end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        issue(1'b0, 2'd2, 1'b1, 32'h84, 32'h0);
        checks++; if (mem_addr !== 32'h84 || mem_we !== 1'b0) begin errors++; $display("FAIL rm_fresh_addr got %h/%b want 84/0", mem_addr, mem_we); end
        step;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_fresh_resp got %b/%h want 1/cafef00d", resp_valid, resp_rdata); end
        step;
    endtask

    task automatic test_dword64;
        mem_ready64 = 1'b1; mem_rdata64 = 64'h0123_4567_89AB_CDEF;
        req_valid64 = 1'b1; req_we64 = 1'b0; req_size64 = 2'd3; req_sign64 = 1'b1; req_addr64 = 32'h8;
        step;
        req_valid64 = 1'b0;
        checks++; if (mem_valid64 !== 1'b1 || mem_addr64 !== 32'h8 || mem_be64 !== 8'hFF) begin errors++; $display("FAIL d64_beat got %b/%h/%h want 1/8/ff", mem_valid64, mem_addr64, mem_be64); end
        step;
        checks++; if (resp_valid64 !== 1'b1 || resp_err64 !== 1'b0) begin errors++; $display("FAIL d64_resp got %b/%b want 1/0", resp_valid64, resp_err64); end
        checks++; if (resp_rdata64 !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL d64_rdata got %h want 0123456789abcdef", resp_rdata64); end
        step;
        mem_rdata64 = 64'h8000_0001_0000_0000;
        req_valid64 = 1'b1; req_size64 = 2'd2; req_sign64 = 1'b1; req_addr64 = 32'hC;
        step;
        req_valid64 = 1'b0;
        checks++; if (mem_addr64 !== 32'h8 || mem_be64 !== 8'hF0) begin errors++; $display("FAIL w64_beat got %h/%h want 8/f0", mem_addr64, mem_be64); end
        step;
        checks++; if (resp_rdata64 !== 64'hFFFF_FFFF_8000_0001) begin errors++; $display("FAIL w64_sext got %h want ffffffff80000001", resp_rdata64); end
        step;
    endtask

    initial begin
        test_reset;
        test_load_byte;
        test_store_half;
        test_split;
        test_wait_states;
        test_illegal_size;
        test_back_to_back;
        test_reset_mid;
        test_dword64;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
